// File: rtl/cpu_defs.sv
// Shared CPU definitions: reset vector, fetch FSM encodings and small address helpers.
package cpu_defs;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'hBFC00000;

    typedef enum logic [1:0] {
        FS_REQ   = 2'd0,
        FS_WAIT  = 2'd1,
        FS_HOLD  = 2'd2,
        FS_DRAIN = 2'd3
    } fetch_state_e;

    function automatic logic misaligned(input logic [31:0] addr);
        return addr[1:0] != 2'b00;
    endfunction

endpackage

// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: one outstanding SRAM-like read at a time, with
// redirect handling that drains a stale response before refetching.
module fetch_ctrl
    import cpu_defs::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc_next,
    input  logic        redirect,
    input  logic        stallF,
    output logic        inst_req,
    output logic [31:0] inst_addr,
    input  logic        inst_addr_ok,
    input  logic        inst_data_ok,
    input  logic [31:0] inst_rdata,
    output logic [31:0] pcF,
    output logic [31:0] instrF,
    output logic        instr_validF,
    output logic        adelF,
    output logic        fetch_busy
);

    fetch_state_e state, state_nx;
    logic [31:0]  pend_pc, pend_nx;
    logic [31:0]  pc_nx;
    logic [31:0]  instr_nx;
    logic         mis;

    assign mis = misaligned(pcF);

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= FS_REQ;
            pcF     <= RESET_PC;
            pend_pc <= '0;
            instrF  <= '0;
        end else begin
            state   <= state_nx;
            pcF     <= pc_nx;
            pend_pc <= pend_nx;
            instrF  <= instr_nx;
        end
    end

    always_comb begin
        state_nx = state;
        pc_nx    = pcF;
        pend_nx  = pend_pc;
        instr_nx = instrF;
        case (state)
            FS_REQ: begin
                if (mis) begin
                    // No bus request for a bad PC; present an address error to decode.
                    if (redirect) begin
                        pc_nx = pc_next;
                    end else begin
                        instr_nx = '0;
                        state_nx = FS_HOLD;
                    end
                end else if (inst_addr_ok) begin
                    if (redirect) begin
                        pend_nx  = pc_next;
                        state_nx = FS_DRAIN;
                    end else begin
                        state_nx = FS_WAIT;
                    end
                end else if (redirect) begin
                    pc_nx = pc_next;
                end
            end
            FS_WAIT: begin
                if (redirect && inst_data_ok) begin
                    // Response already arrived this cycle, so there is nothing left to drain.
                    pc_nx    = pc_next;
                    state_nx = FS_REQ;
                end else if (redirect) begin
                    pend_nx  = pc_next;
                    state_nx = FS_DRAIN;
                end else if (inst_data_ok) begin
                    instr_nx = inst_rdata;
                    state_nx = FS_HOLD;
                end
            end
            FS_HOLD: begin
                if (redirect || !stallF) begin
                    pc_nx    = pc_next;
                    state_nx = FS_REQ;
                end
            end
            FS_DRAIN: begin
                if (inst_data_ok) begin
                    pc_nx    = redirect ? pc_next : pend_pc;
                    pend_nx  = redirect ? pc_next : pend_pc;
                    state_nx = FS_REQ;
                end else if (redirect) begin
                    pend_nx = pc_next;
                end
            end
            default: begin
                state_nx = FS_REQ;
            end
        endcase
    end

    assign inst_req     = (state == FS_REQ) && !mis && !rst;
    assign inst_addr    = pcF;
    assign instr_validF = (state == FS_HOLD);
    assign adelF        = instr_validF && mis;
    assign fetch_busy   = (state != FS_HOLD);

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl with a scoreboard of expected decode handoffs.
module tb_fetch_ctrl;

    logic        clk;
    logic        rst;
    logic [31:0] pc_next;
    logic        redirect;
    logic        stallF;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_addr_ok;
    logic        inst_data_ok;
    logic [31:0] inst_rdata;
    logic [31:0] pcF;
    logic [31:0] instrF;
    logic        instr_validF;
    logic        adelF;
    logic        fetch_busy;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        adel;
    } exp_t;

    exp_t sb[$];
    int   vectors;
    int   miscompares;
    logic prev_vld;

    fetch_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .pc_next      (pc_next),
        .redirect     (redirect),
        .stallF       (stallF),
        .inst_req     (inst_req),
        .inst_addr    (inst_addr),
        .inst_addr_ok (inst_addr_ok),
        .inst_data_ok (inst_data_ok),
        .inst_rdata   (inst_rdata),
        .pcF          (pcF),
        .instrF       (instrF),
        .instr_validF (instr_validF),
        .adelF        (adelF),
        .fetch_busy   (fetch_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input logic [31:0] pc, input logic [31:0] instr, input logic adel);
        exp_t e;
        e.pc    = pc;
        e.instr = instr;
        e.adel  = adel;
        sb.push_back(e);
    endtask

    // Each rising edge of instr_validF must match the oldest expected handoff.
    initial prev_vld = 1'b0;
    always @(negedge clk) begin
        if (instr_validF === 1'b1 && prev_vld !== 1'b1) begin
            if (sb.size() == 0) begin
                chk("unexpected_valid", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("sb_pcF", pcF, e.pc);
                chk("sb_instrF", instrF, e.instr);
                chk("sb_adelF", {31'd0, adelF}, {31'd0, e.adel});
            end
        end
        prev_vld = instr_validF;
    end

    initial begin
        vectors      = 0;
        miscompares  = 0;
        rst          = 1'b1;
        pc_next      = '0;
        redirect     = 1'b0;
        stallF       = 1'b0;
        inst_addr_ok = 1'b0;
        inst_data_ok = 1'b0;
        inst_rdata   = '0;

        // Reset state
        tick();
        tick();
        chk("rst_inst_req", {31'd0, inst_req}, 32'd0);
        chk("rst_pcF", pcF, 32'hBFC00000);
        chk("rst_instrF", instrF, 32'h0);
        chk("rst_valid", {31'd0, instr_validF}, 32'd0);
        chk("rst_adel", {31'd0, adelF}, 32'd0);
        rst = 1'b0;
        #1;
        chk("post_rst_req", {31'd0, inst_req}, 32'd1);
        chk("post_rst_addr", inst_addr, 32'hBFC00000);
        chk("post_rst_busy", {31'd0, fetch_busy}, 32'd1);

        // Basic fetch: addr_ok at cycle 1, data_ok at cycle 3, valid at cycle 4
        inst_addr_ok = 1'b1;
        tick();
        inst_addr_ok = 1'b0;
        chk("wait_req", {31'd0, inst_req}, 32'd0);
        chk("wait_busy", {31'd0, fetch_busy}, 32'd1);
        chk("wait_valid", {31'd0, instr_validF}, 32'd0);
        tick();
        inst_data_ok = 1'b1;
        inst_rdata   = 32'h24080001;
        push_exp(32'hBFC00000, 32'h24080001, 1'b0);
        tick();
        inst_data_ok = 1'b0;
        inst_rdata   = 32'h0;
        chk("hold_valid", {31'd0, instr_validF}, 32'd1);
        chk("hold_busy", {31'd0, fetch_busy}, 32'd0);
        chk("hold_req", {31'd0, inst_req}, 32'd0);

        // Stall in HOLD for three cycles, then advance sequentially
        stallF  = 1'b1;
        pc_next = 32'hBFC00004;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_valid", {31'd0, instr_validF}, 32'd1);
            chk("stall_pcF", pcF, 32'hBFC00000);
            chk("stall_instrF", instrF, 32'h24080001);
            chk("stall_req", {31'd0, inst_req}, 32'd0);
        end
        stallF = 1'b0;
        tick();
        chk("seq_req", {31'd0, inst_req}, 32'd1);
        chk("seq_addr", inst_addr, 32'hBFC00004);
        chk("seq_valid", {31'd0, instr_validF}, 32'd0);

        // Redirect while WAIT: stale response is dropped
        inst_addr_ok = 1'b1;
        tick();
        inst_addr_ok = 1'b0;
        redirect     = 1'b1;
        pc_next      = 32'hBFC00380;
        tick();
        redirect = 1'b0;
        pc_next  = 32'h0;
        chk("drain_req", {31'd0, inst_req}, 32'd0);
        chk("drain_busy", {31'd0, fetch_busy}, 32'd1);
        tick();
        inst_data_ok = 1'b1;
        inst_rdata   = 32'hDEADBEEF;
        tick();
        inst_data_ok = 1'b0;
        inst_rdata   = 32'h0;
        chk("drained_req", {31'd0, inst_req}, 32'd1);
        chk("drained_addr", inst_addr, 32'hBFC00380);
        chk("drained_instrF", instrF, 32'h24080001);
        chk("drained_valid", {31'd0, instr_validF}, 32'd0);

        // Redirect in REQ before addr_ok
        redirect = 1'b1;
        pc_next  = 32'h80001000;
        tick();
        redirect = 1'b0;
        chk("req_redir_req", {31'd0, inst_req}, 32'd1);
        chk("req_redir_addr", inst_addr, 32'h80001000);
        inst_addr_ok = 1'b1;
        tick();
        inst_addr_ok = 1'b0;
        inst_data_ok = 1'b1;
        inst_rdata   = 32'h3C1D8000;
        push_exp(32'h80001000, 32'h3C1D8000, 1'b0);
        tick();
        inst_data_ok = 1'b0;
        chk("fast_valid", {31'd0, instr_validF}, 32'd1);

        // Misaligned next PC: no request, address error presented to decode
        pc_next = 32'h80000002;
        tick();
        pc_next = 32'h0;
        chk("mis_req", {31'd0, inst_req}, 32'd0);
        chk("mis_busy", {31'd0, fetch_busy}, 32'd1);
        push_exp(32'h80000002, 32'h0, 1'b1);
        tick();
        chk("mis_valid", {31'd0, instr_validF}, 32'd1);
        chk("mis_adel", {31'd0, adelF}, 32'd1);

        // Redirect in HOLD overrides stall
        stallF   = 1'b1;
        redirect = 1'b1;
        pc_next  = 32'h80000100;
        tick();
        stallF   = 1'b0;
        redirect = 1'b0;
        chk("hold_redir_req", {31'd0, inst_req}, 32'd1);
        chk("hold_redir_addr", inst_addr, 32'h80000100);
        chk("hold_redir_adel", {31'd0, adelF}, 32'd0);

        // Redirect with addr_ok, then a later redirect with data_ok wins
        inst_addr_ok = 1'b1;
        redirect     = 1'b1;
        pc_next      = 32'h80000200;
        tick();
        inst_addr_ok = 1'b0;
        redirect     = 1'b0;
        chk("drain2_req", {31'd0, inst_req}, 32'd0);
        tick();
        inst_data_ok = 1'b1;
        redirect     = 1'b1;
        pc_next      = 32'h80000300;
        inst_rdata   = 32'hCAFEF00D;
        tick();
        inst_data_ok = 1'b0;
        redirect     = 1'b0;
        chk("last_wins_addr", inst_addr, 32'h80000300);
        chk("last_wins_req", {31'd0, inst_req}, 32'd1);

        // Reset mid-transaction
        inst_addr_ok = 1'b1;
        tick();
        inst_addr_ok = 1'b0;
        rst          = 1'b1;
        tick();
        chk("midrst_pcF", pcF, 32'hBFC00000);
        chk("midrst_req", {31'd0, inst_req}, 32'd0);
        chk("midrst_valid", {31'd0, instr_validF}, 32'd0);
        rst = 1'b0;
        #1;
        chk("midrst_fresh_req", {31'd0, inst_req}, 32'd1);
        chk("midrst_fresh_addr", inst_addr, 32'hBFC00000);
        inst_addr_ok = 1'b1;
        tick();
        inst_addr_ok = 1'b0;
        inst_data_ok = 1'b1;
        inst_rdata   = 32'h11111111;
        push_exp(32'hBFC00000, 32'h11111111, 1'b0);
        tick();
        inst_data_ok = 1'b0;
        tick();
        chk("sb_drained", sb.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
